prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 93 +++++++++
 tb/tb_prog_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, big-endian byte stream, writes 32-bit words into
// CPU instruction memory, and then releases the CPU from reset.
module prog_loader #(
  parameter int MAX_WORDS = 32
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] Instruction,
  output logic        LoadInstructions,
  output logic [7:0]  LoadAddr,
  output logic        CpuReset,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, HDR, ASSEMBLE, WRITE, RELEASE, DONE, ERR} stateT;
  localparam logic [8:0] MaxW = 9'(MAX_WORDS);
  stateT state, nextState;
  logic [31:0] word, nextWord;
  logic [7:0] wordIdx, nextWordIdx, wordCount, nextWordCount;
  logic [1:0] byteIdx, nextByteIdx, relCnt, nextRelCnt;
  logic xfer;
  assign xfer = byte_valid & byte_ready;
  always_comb begin
    nextState = state;
    nextWord = word;
    nextWordIdx = wordIdx;
    nextWordCount = wordCount;
    nextByteIdx = byteIdx;
    nextRelCnt = relCnt;
    case (state)
      IDLE, DONE: nextState = start ? HDR : state;
      HDR: if (xfer) begin
        nextWordCount = byte_in;
        nextWordIdx = '0;
        nextByteIdx = '0;
        nextRelCnt = '0;
        nextState = byte_in == 8'd0 ? RELEASE : {1'b0, byte_in} > MaxW ? ERR : ASSEMBLE;
      end
      ASSEMBLE: if (xfer) begin
        nextWord = {word[23:0], byte_in};
        nextByteIdx = byteIdx + 2'd1;
        nextState = byteIdx == 2'd3 ? WRITE : ASSEMBLE;
      end
      WRITE: begin
        nextByteIdx = '0;
        nextRelCnt = '0;
        nextState = wordIdx == wordCount - 8'd1 ? RELEASE : ASSEMBLE;
        nextWordIdx = wordIdx == wordCount - 8'd1 ? wordIdx : wordIdx + 8'd1;
      end
      RELEASE: begin
        nextRelCnt = relCnt + 2'd1;
        nextState = relCnt == 2'd1 ? DONE : RELEASE;
      end
      default: ;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state <= IDLE;
      word <= '0;
      wordIdx <= '0;
      wordCount <= '0;
      byteIdx <= '0;
      relCnt <= '0;
      byte_ready <= 1'b0;
      Instruction <= '0;
      LoadInstructions <= 1'b0;
      LoadAddr <= '0;
      CpuReset <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nextState;
      word <= nextWord;
      wordIdx <= nextWordIdx;
      wordCount <= nextWordCount;
      byteIdx <= nextByteIdx;
      relCnt <= nextRelCnt;
      byte_ready <= nextState == HDR || nextState == ASSEMBLE;
      LoadInstructions <= nextState == WRITE;
      Instruction <= nextState == WRITE ? nextWord : Instruction;
      LoadAddr <= nextState == WRITE ? nextWordIdx : LoadAddr;
      CpuReset <= nextState != DONE;
      done <= nextState == DONE;
      error <= nextState == ERR;
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized scoreboard bench; expected (addr, word) writes are queued per session
// and a monitor pops them whenever the loader strobes LoadInstructions.
module tb_prog_loader;
  localparam int MAX_WORDS = 32;
  logic clk = 0, Reset = 0, start = 0, byte_valid = 0;
  logic [7:0] byte_in = '0;
  logic byte_ready, LoadInstructions, CpuReset, done, error;
  logic [31:0] Instruction;
  logic [7:0] LoadAddr;
  int passCnt = 0, totalCnt = 0, gapMode = 0;
  logic [31:0] words[$];
  logic [39:0] expQ[$];

  prog_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .Reset(Reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .Instruction(Instruction), .LoadInstructions(LoadInstructions),
    .LoadAddr(LoadAddr), .CpuReset(CpuReset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (LoadInstructions) begin
      if (expQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_strobe: got addr %0h word %0h expected no strobe", LoadAddr, Instruction);
      end else check("write", {LoadAddr, Instruction}, expQ.pop_front());
    end
  end

  task automatic checkReset();
    check("reset_outs", {byte_ready, LoadInstructions, CpuReset, done, error}, 5'b00100);
    check("reset_data", {LoadAddr, Instruction}, 40'h0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = gapMode == 1 ? 1 : gapMode == 2 ? int'($urandom_range(0, 2)) : 0;
    byte_valid = 0;
    repeat (n) @(negedge clk);
    byte_in = b;
    byte_valid = 1;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      totalCnt++;
      $display("FAIL byte_accept: got byte_ready 0 for byte %0h expected 1 within 50 cycles", b);
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic waitDone(input int expK);
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("release_cycles", k, expK);
    check("done_state", {done, CpuReset}, 2'b10);
  endtask

  task automatic session(input logic [7:0] hdr, input bit noise);
    start = 1;
    @(negedge clk);
    start = 0;
    check("hdr_entry", {byte_ready, CpuReset, done}, 3'b110);
    if (hdr <= MAX_WORDS)
      for (int i = 0; i < words.size(); i++) expQ.push_back({8'(i), words[i]});
    sendByte(hdr);
    if (hdr > MAX_WORDS) return;
    for (int i = 0; i < words.size(); i++) begin
      if (noise && i == 0) start = 1;
      for (int b = 3; b >= 0; b--) sendByte(words[i][8*b +: 8]);
      start = 0;
      check("strobe_latency", LoadInstructions, 1'b1);
    end
    waitDone(hdr == 0 ? 2 : 3);
  endtask

  task automatic randWords(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkReset();
    Reset = 1;
    @(negedge clk);
    check("idle_hold", {byte_ready, CpuReset, done}, 3'b010);
    words = '{32'h20010005, 32'hAC020000};
    session(8'd2, 0);
    gapMode = 1;
    session(8'd2, 0);
    gapMode = 0;
    words.delete();
    session(8'd0, 0);
    words = '{32'hFFFFFFFF};
    session(8'd1, 0);
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, 8);
      gapMode = 2;
      randWords(n);
      session(8'(n), 1);
    end
    gapMode = 0;
    randWords(32);
    session(8'd32, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    sendByte(8'd2);
    sendByte(8'h11);
    sendByte(8'h22);
    Reset = 0;
    @(negedge clk);
    Reset = 1;
    checkReset();
    repeat (3) @(negedge clk);
    check("idle_after_abort", {byte_ready, CpuReset, done}, 3'b010);
    randWords(2);
    session(8'd2, 0);
    words.delete();
    session(8'd33, 0);
    check("err_entry", {error, CpuReset, byte_ready, done}, 4'b1100);
    start = 1;
    byte_in = 8'h01;
    byte_valid = 1;
    repeat (6) @(negedge clk);
    check("err_sticky", {error, CpuReset, byte_ready, LoadInstructions}, 4'b1100);
    start = 0;
    byte_valid = 0;
    Reset = 0;
    @(negedge clk);
    Reset = 1;
    checkReset();
    check("queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
